ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_pkg.sv | 36 +++
 rtl/ps2_ascii_lut.sv | 76 +++++++
 rtl/ps2_key_decoder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ps2_pkg
//  Description : Shared definitions for the PS/2 scan-code decoder: the
//                prefix-sequence state encoding, the special scan-code
//                constants and the length of the Pause-key tail.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Prefix-sequence states. Each state is followed by a one-cycle POP
    // sub-cycle, tracked separately by the decoder's pop flag.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BRK    = 3'd1,
        ST_EXT    = 3'd2,
        ST_EXTBRK = 3'd3,
        ST_SKIP   = 3'd4
    } seq_state_t;

    localparam logic [7:0] CODE_BREAK  = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_PAUSE  = 8'hE1;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;

    // Bytes discarded after the E1 that opens the Pause sequence.
    localparam logic [2:0] SKIP_LEN    = 3'd7;

    // True for the two (non-extended) Shift scan codes.
    function automatic logic is_shift_code(input logic ext, input logic [7:0] code);
        return !ext && ((code == CODE_LSHIFT) || (code == CODE_RSHIFT));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_ascii_lut.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_ascii_lut
//  Description : Combinational scan-code-set-2 to ASCII table covering
//                letters, digits and space. Extended codes and anything not
//                in the table map to 00h.
//  Ports       : ext   - code carried an E0 prefix
//                code  - scan code
//                upper - select upper-case letters
//                ascii - resulting ASCII byte (00h when unmapped)
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_ascii_lut (
    input  logic       ext,
    input  logic [7:0] code,
    input  logic       upper,
    output logic [7:0] ascii
);

    logic [7:0] lower;

    always_comb begin
        lower = 8'h00;
        case (code)
            8'h1C: lower = 8'h61; // a
            8'h32: lower = 8'h62; // b
            8'h21: lower = 8'h63; // c
            8'h23: lower = 8'h64; // d
            8'h24: lower = 8'h65; // e
            8'h2B: lower = 8'h66; // f
            8'h34: lower = 8'h67; // g
            8'h33: lower = 8'h68; // h
            8'h43: lower = 8'h69; // i
            8'h3B: lower = 8'h6A; // j
            8'h42: lower = 8'h6B; // k
            8'h4B: lower = 8'h6C; // l
            8'h3A: lower = 8'h6D; // m
            8'h31: lower = 8'h6E; // n
            8'h44: lower = 8'h6F; // o
            8'h4D: lower = 8'h70; // p
            8'h15: lower = 8'h71; // q
            8'h2D: lower = 8'h72; // r
            8'h1B: lower = 8'h73; // s
            8'h2C: lower = 8'h74; // t
            8'h3C: lower = 8'h75; // u
            8'h2A: lower = 8'h76; // v
            8'h1D: lower = 8'h77; // w
            8'h22: lower = 8'h78; // x
            8'h35: lower = 8'h79; // y
            8'h1A: lower = 8'h7A; // z
            8'h45: lower = 8'h30; // 0
            8'h16: lower = 8'h31; // 1
            8'h1E: lower = 8'h32; // 2
            8'h26: lower = 8'h33; // 3
            8'h25: lower = 8'h34; // 4
            8'h2E: lower = 8'h35; // 5
            8'h36: lower = 8'h36; // 6
            8'h3D: lower = 8'h37; // 7
            8'h3E: lower = 8'h38; // 8
            8'h46: lower = 8'h39; // 9
            8'h29: lower = 8'h20; // space
            default: lower = 8'h00;
        endcase

        // Shift only changes letters; digits and space are unaffected.
        if (ext) begin
            ascii = 8'h00;
        end else if (upper && (lower >= 8'h61) && (lower <= 8'h7A)) begin
            ascii = lower - 8'h20;
        end else begin
            ascii = lower;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_decoder
//  Description : Pops bytes from a PS/2 keyboard FIFO, tracks the E0/F0/E1
//                prefix sequences and emits one registered make/break event
//                per complete scan code. Tracks Shift, the currently held
//                key (optionally filtering typematic repeats), counts
//                accepted presses and latches FIFO overflow.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                kb_data         - FIFO head byte
//                kb_ready        - FIFO non-empty
//                kb_overflow     - FIFO overflow indication
//                kb_nextdata_n   - active-low FIFO pop (one cycle)
//                key_valid       - one-cycle event strobe
//                key_make        - 1 press / 0 release
//                key_ext         - event had an E0 prefix
//                key_code        - scan code of last event
//                key_ascii       - ASCII of key_code (00h if unmapped)
//                key_held        - a non-modifier key is held
//                press_cnt       - accepted make events (wrapping)
//                err_ovf         - sticky overflow flag
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int CNT_W         = 8,
    parameter int REPEAT_FILTER = 1,
    parameter int SHIFT_EN      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       kb_data,
    input  logic             kb_ready,
    input  logic             kb_overflow,
    output logic             kb_nextdata_n,
    output logic             key_valid,
    output logic             key_make,
    output logic             key_ext,
    output logic [7:0]       key_code,
    output logic [7:0]       key_ascii,
    output logic             key_held,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err_ovf
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    seq_state_t       state, state_n;
    logic             pop, pop_n;
    logic [2:0]       skip_cnt, skip_cnt_n;
    logic [8:0]       held_key, held_key_n;       // {ext, code}
    logic             held_flag, held_flag_n;
    logic             shift_l, shift_l_n;
    logic             shift_r, shift_r_n;
    logic             valid_n;
    logic             make_n;
    logic             ext_n;
    logic [7:0]       code_n;
    logic [CNT_W-1:0] cnt_n;

    logic             capture;
    logic             term;        // captured byte completes a scan code
    logic             term_make;
    logic             term_ext;
    logic             upper;

    // A byte is taken only outside the POP sub-cycle, so throughput is at
    // most one byte every two cycles and kb_ready is ignored during POP.
    assign capture = kb_ready && kb_nextdata_n && !pop;

    // ------------------------------------------------------------------
    // Next-state / event logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n     = state;
        pop_n       = capture;
        skip_cnt_n  = skip_cnt;
        held_key_n  = held_key;
        held_flag_n = held_flag;
        shift_l_n   = shift_l;
        shift_r_n   = shift_r;
        valid_n     = 1'b0;
        make_n      = key_make;
        ext_n       = key_ext;
        code_n      = key_code;
        cnt_n       = press_cnt;
        term        = 1'b0;
        term_make   = 1'b0;
        term_ext    = 1'b0;

        if (capture) begin
            case (state)
                ST_IDLE: begin
                    if (kb_data == CODE_BREAK) begin
                        state_n = ST_BRK;
                    end else if (kb_data == CODE_EXT) begin
                        state_n = ST_EXT;
                    end else if (kb_data == CODE_PAUSE) begin
                        state_n    = ST_SKIP;
                        skip_cnt_n = 3'd0;
                    end else begin
                        term      = 1'b1;
                        term_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (kb_data == CODE_BREAK) begin
                        state_n = ST_EXTBRK;
                    end else if ((kb_data == CODE_EXT) || (kb_data == CODE_PAUSE)) begin
                        state_n = ST_EXT;    // redundant prefix, discard
                    end else begin
                        state_n   = ST_IDLE;
                        term      = 1'b1;
                        term_make = 1'b1;
                        term_ext  = 1'b1;
                    end
                end
                ST_BRK, ST_EXTBRK: begin
                    if (kb_data == CODE_BREAK) begin
                        state_n = state;
                    end else if (kb_data == CODE_EXT) begin
                        state_n = ST_EXTBRK;
                    end else if (kb_data == CODE_PAUSE) begin
                        state_n    = ST_SKIP;
                        skip_cnt_n = 3'd0;
                    end else begin
                        state_n  = ST_IDLE;
                        term     = 1'b1;
                        term_ext = (state == ST_EXTBRK);
                    end
                end
                ST_SKIP: begin
                    if (skip_cnt == (SKIP_LEN - 3'd1)) begin
                        state_n    = ST_IDLE;
                        skip_cnt_n = 3'd0;
                    end else begin
                        skip_cnt_n = skip_cnt + 3'd1;
                    end
                end
                default: begin
                    state_n    = ST_IDLE;
                    skip_cnt_n = 3'd0;
                end
            endcase
        end

        if (term) begin
            if (is_shift_code(term_ext, kb_data)) begin
                // Modifiers always report, but never touch held/count.
                if (kb_data == CODE_LSHIFT) shift_l_n = term_make;
                else                        shift_r_n = term_make;
                valid_n = 1'b1;
            end else if (term_make) begin
                if ((REPEAT_FILTER != 0) && held_flag && (held_key == {term_ext, kb_data})) begin
                    valid_n = 1'b0;   // typematic repeat of the held key
                end else begin
                    valid_n     = 1'b1;
                    held_key_n  = {term_ext, kb_data};
                    held_flag_n = 1'b1;
                    cnt_n       = press_cnt + CNT_W'(1);
                end
            end else begin
                valid_n = 1'b1;
                if (held_flag && (held_key == {term_ext, kb_data})) begin
                    held_flag_n = 1'b0;
                end
            end

            if (valid_n) begin
                make_n = term_make;
                ext_n  = term_ext;
                code_n = kb_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            pop           <= 1'b0;
            kb_nextdata_n <= 1'b1;
            skip_cnt      <= 3'd0;
            held_key      <= 9'd0;
            held_flag     <= 1'b0;
            shift_l       <= 1'b0;
            shift_r       <= 1'b0;
            key_valid     <= 1'b0;
            key_make      <= 1'b0;
            key_ext       <= 1'b0;
            key_code      <= 8'h00;
            press_cnt     <= '0;
            err_ovf       <= 1'b0;
        end else begin
            state         <= state_n;
            pop           <= pop_n;
            kb_nextdata_n <= !pop_n;
            skip_cnt      <= skip_cnt_n;
            held_key      <= held_key_n;
            held_flag     <= held_flag_n;
            shift_l       <= shift_l_n;
            shift_r       <= shift_r_n;
            key_valid     <= valid_n;
            key_make      <= make_n;
            key_ext       <= ext_n;
            key_code      <= code_n;
            press_cnt     <= cnt_n;
            if (kb_overflow) err_ovf <= 1'b1;
        end
    end

    assign key_held = held_flag;
    assign upper    = (SHIFT_EN != 0) && (shift_l || shift_r);

    ps2_ascii_lut u_ascii_lut (
        .ext   (key_ext),
        .code  (key_code),
        .upper (upper),
        .ascii (key_ascii)
    );

endmodule
`default_nettype wire
